// File: rtl/game_pkg.sv
// Shared encodings for the N x N tic-tac-toe engine: result codes, cell codes,
// scan directions with their row/col steps, and the engine FSM states.
package game_pkg;

    localparam logic [1:0] RES_PLAY = 2'b00;
    localparam logic [1:0] RES_XWIN = 2'b01;
    localparam logic [1:0] RES_OWIN = 2'b10;
    localparam logic [1:0] RES_DRAW = 2'b11;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_X     = 2'b01;
    localparam logic [1:0] CELL_O     = 2'b10;

    typedef enum logic [1:0] {
        DIR_H,
        DIR_V,
        DIR_D,
        DIR_A
    } dir_t;

    typedef enum logic [2:0] {
        ST_WAIT,
        ST_PLACE,
        ST_CHECK,
        ST_VERDICT,
        ST_DONE
    } state_t;

    function automatic int dir_dr(input dir_t d);
        case (d)
            DIR_H:   return 0;
            default: return 1;
        endcase
    endfunction

    // Anti-diagonal walks down and to the left.
    function automatic int dir_dc(input dir_t d);
        case (d)
            DIR_H:   return 1;
            DIR_V:   return 0;
            DIR_D:   return 1;
            default: return -1;
        endcase
    endfunction

endpackage

// File: rtl/nxn_line_scan.sv
// Maps (placed cell, direction, signed offset) to a board cell; purely combinational.
// Works in row/col space so a step past a row edge is off-board, never the next row.
module nxn_line_scan
    import game_pkg::*;
#(
    parameter int N  = 3,
    parameter int CW = $clog2(N*N+1)
) (
    input  logic [CW-1:0]     pos,
    input  dir_t              dir,
    input  logic signed [4:0] offset,
    output logic              on_board,
    output logic [CW-1:0]     idx
);

    int row;
    int col;
    int r;
    int c;

    always_comb begin
        row      = int'(pos) / N;
        col      = int'(pos) % N;
        r        = row + dir_dr(dir) * int'(offset);
        c        = col + dir_dc(dir) * int'(offset);
        on_board = (r >= 0) && (r < N) && (c >= 0) && (c < N);
        idx      = on_board ? CW'(r * N + c) : '0;
    end

endmodule

// File: rtl/game_state_nxn.sv
// N x N, K-in-a-row game engine: handshake-to-verdict latency is 4*(2K-1)+2 cycles.
// key_ready drops outside WAIT and while is_main is high; illegal keys get a reject pulse.
module game_state_nxn
    import game_pkg::*;
#(
    parameter int  N       = 3,
    parameter int  K       = 3,
    parameter bit  FIRST_O = 1'b0,
    localparam int CW      = $clog2(N*N+1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            is_main,
    input  logic            new_game,
    input  logic            key_valid,
    input  logic [CW-1:0]   key_data,
    output logic            key_ready,
    output logic            reject,
    output logic [2*N*N-1:0] board,
    output logic            turn_o,
    output logic [1:0]      result,
    output logic [CW-1:0]   move_count,
    output logic            busy
);

    localparam int                NC      = N * N;
    localparam logic [CW-1:0]     NC_CNT  = CW'(NC);
    localparam logic [3:0]        K_RUN   = 4'(K);
    localparam logic signed [4:0] OFF_MIN = 5'(1 - K);
    localparam logic signed [4:0] OFF_MAX = 5'(K - 1);

    state_t            state;
    state_t            state_nxt;
    logic [2*NC-1:0]   board_q;
    logic [CW-1:0]     pos;
    dir_t              dir;
    logic signed [4:0] off;
    logic [3:0]        run;
    logic [3:0]        run_nxt;
    logic              win;
    logic              handshake;
    logic              key_bad;
    logic              scan_on;
    logic [CW-1:0]     scan_idx;
    logic              hit;
    logic [1:0]        mover;

    // Cell j (0-based) sits in the board word with cell 0 at the MSB end.
    function automatic logic [1:0] cell_at(input logic [2*NC-1:0] b, input int j);
        return b[2*(NC-1-j) +: 2];
    endfunction

    nxn_line_scan #(.N(N), .CW(CW)) u_scan (
        .pos      (pos),
        .dir      (dir),
        .offset   (off),
        .on_board (scan_on),
        .idx      (scan_idx)
    );

    assign key_ready = (state == ST_WAIT) && !is_main;
    assign handshake = key_valid && key_ready;
    assign busy      = (state == ST_PLACE) || (state == ST_CHECK) || (state == ST_VERDICT);
    assign board     = board_q;
    assign mover     = turn_o ? CELL_O : CELL_X;

    always_comb begin
        key_bad = 1'b1;
        if (key_data != '0 && key_data <= NC_CNT)
            key_bad = (cell_at(board_q, int'(key_data) - 1) != CELL_EMPTY);
    end

    always_comb begin
        hit     = scan_on && (cell_at(board_q, int'(scan_idx)) == mover);
        run_nxt = hit ? run + 4'd1 : 4'd0;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_WAIT:    if (handshake && !key_bad) state_nxt = ST_PLACE;
            ST_PLACE:   state_nxt = ST_CHECK;
            ST_CHECK:   if (off == OFF_MAX && dir == DIR_A) state_nxt = ST_VERDICT;
            ST_VERDICT: state_nxt = (win || move_count == NC_CNT) ? ST_DONE : ST_WAIT;
            ST_DONE:    state_nxt = ST_DONE;
            default:    state_nxt = ST_WAIT;
        endcase
        if (new_game)
            state_nxt = ST_WAIT;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_WAIT;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst || new_game) begin
            board_q    <= '0;
            result     <= RES_PLAY;
            move_count <= '0;
            turn_o     <= FIRST_O;
            reject     <= 1'b0;
            pos        <= '0;
            dir        <= DIR_H;
            off        <= OFF_MIN;
            run        <= 4'd0;
            win        <= 1'b0;
        end else begin
            reject <= 1'b0;
            case (state)
                ST_WAIT: begin
                    if (handshake) begin
                        if (key_bad)
                            reject <= 1'b1;
                        else
                            pos <= key_data - CW'(1);
                    end
                end
                ST_PLACE: begin
                    board_q[2*(NC-1-int'(pos)) +: 2] <= mover;
                    move_count <= move_count + CW'(1);
                    dir <= DIR_H;
                    off <= OFF_MIN;
                    run <= 4'd0;
                    win <= 1'b0;
                end
                ST_CHECK: begin
                    if (run_nxt >= K_RUN)
                        win <= 1'b1;
                    // A run never carries across a direction change.
                    if (off == OFF_MAX) begin
                        off <= OFF_MIN;
                        dir <= dir_t'(dir + 2'd1);
                        run <= 4'd0;
                    end else begin
                        off <= off + 5'sd1;
                        run <= run_nxt;
                    end
                end
                ST_VERDICT: begin
                    if (win)
                        result <= turn_o ? RES_OWIN : RES_XWIN;
                    else if (move_count == NC_CNT)
                        result <= RES_DRAW;
                    else
                        turn_o <= !turn_o;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_game_state_nxn.sv
// Directed bench for game_state_nxn: a 3x3 and a 4x4 (K=3) engine share stimulus,
// key_valid is steered to one of them by sel.
module tb_game_state_nxn;

    logic       clk = 1'b0;
    logic       rst;
    logic       is_main;
    logic       new_game;
    logic       key_valid;
    logic       sel;
    logic [4:0] kd;

    logic        kr3, rej3, t3, busy3;
    logic [17:0] brd3;
    logic [1:0]  res3;
    logic [3:0]  mc3;
    logic        kr4, rej4, t4, busy4;
    logic [31:0] brd4;
    logic [1:0]  res4;
    logic [4:0]  mc4;

    logic       kv3, kv4;
    logic       kr, rej, trn, bsy;
    logic [1:0] res;
    logic [4:0] mc;

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign kv3 = key_valid & ~sel;
    assign kv4 = key_valid & sel;
    assign kr  = sel ? kr4   : kr3;
    assign rej = sel ? rej4  : rej3;
    assign trn = sel ? t4    : t3;
    assign bsy = sel ? busy4 : busy3;
    assign res = sel ? res4  : res3;
    assign mc  = sel ? mc4   : {1'b0, mc3};

    game_state_nxn #(.N(3), .K(3), .FIRST_O(1'b0)) dut3 (
        .clk(clk), .rst(rst), .is_main(is_main), .new_game(new_game),
        .key_valid(kv3), .key_data(kd[3:0]), .key_ready(kr3), .reject(rej3),
        .board(brd3), .turn_o(t3), .result(res3), .move_count(mc3), .busy(busy3)
    );

    game_state_nxn #(.N(4), .K(3), .FIRST_O(1'b0)) dut4 (
        .clk(clk), .rst(rst), .is_main(is_main), .new_game(new_game),
        .key_valid(kv4), .key_data(kd), .key_ready(kr4), .reject(rej4),
        .board(brd4), .turn_o(t4), .result(res4), .move_count(mc4), .busy(busy4)
    );

    typedef struct {
        bit s;
        bit ng;
        int key;
        bit rej;
        bit turn;
        int cnt;
        int res;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_ng();
        new_game = 1'b1;
        step();
        new_game = 1'b0;
    endtask

    task automatic add(input bit s, input bit ng, input int key, input bit rj,
                       input bit turn, input int cnt, input int r);
        vec_t v;
        v.s = s; v.ng = ng; v.key = key; v.rej = rj;
        v.turn = turn; v.cnt = cnt; v.res = r;
        vecs.push_back(v);
    endtask

    initial begin
        int n;
        rst = 1'b1; is_main = 1'b0; new_game = 1'b0; key_valid = 1'b0;
        sel = 1'b0; kd = '0;

        // 3x3: X takes the top row on move 5
        add(0,1, 1,0,1,1,0); add(0,0, 4,0,0,2,0); add(0,0, 2,0,1,3,0);
        add(0,0, 5,0,0,4,0); add(0,0, 3,0,0,5,1);
        // 3x3: occupied cell, key 0, key 10
        add(0,1, 1,0,1,1,0); add(0,0, 1,1,1,1,0); add(0,0, 0,1,1,1,0);
        add(0,0,10,1,1,1,0);
        // 3x3: O wins the middle row
        add(0,1, 1,0,1,1,0); add(0,0, 4,0,0,2,0); add(0,0, 2,0,1,3,0);
        add(0,0, 5,0,0,4,0); add(0,0, 9,0,1,5,0); add(0,0, 6,0,1,6,2);
        // 3x3: full board, no line
        add(0,1, 1,0,1,1,0); add(0,0, 2,0,0,2,0); add(0,0, 3,0,1,3,0);
        add(0,0, 5,0,0,4,0); add(0,0, 4,0,1,5,0); add(0,0, 6,0,0,6,0);
        add(0,0, 8,0,1,7,0); add(0,0, 7,0,0,8,0); add(0,0, 9,0,0,9,3);
        // 3x3: ninth move completes the main diagonal
        add(0,1, 1,0,1,1,0); add(0,0, 2,0,0,2,0); add(0,0, 3,0,1,3,0);
        add(0,0, 4,0,0,4,0); add(0,0, 5,0,1,5,0); add(0,0, 6,0,0,6,0);
        add(0,0, 8,0,1,7,0); add(0,0, 7,0,0,8,0); add(0,0, 9,0,0,9,1);
        // 4x4 K=3: X on main diagonal 2,7,12
        add(1,1, 2,0,1,1,0); add(1,0, 1,0,0,2,0); add(1,0, 7,0,1,3,0);
        add(1,0, 5,0,0,4,0); add(1,0,12,0,0,5,1);
        // 4x4 K=3: X on 3,4,5 wraps a row edge, no win; key 17 off-board
        add(1,1, 3,0,1,1,0); add(1,0,10,0,0,2,0); add(1,0, 4,0,1,3,0);
        add(1,0,15,0,0,4,0); add(1,0, 5,0,1,5,0); add(1,0,17,1,1,5,0);

        step(); step();
        rst = 1'b0;
        chk("rst_board3", int'(brd3), 0);
        chk("rst_board4", int'(brd4), 0);
        chk("rst_result", int'(res), 0);
        chk("rst_count", int'(mc), 0);
        chk("rst_turn", int'(trn), 0);
        chk("rst_reject", int'(rej), 0);
        chk("rst_busy", int'(bsy), 0);
        chk("rst_key_ready", int'(kr), 1);

        foreach (vecs[i]) begin
            sel = vecs[i].s;
            if (vecs[i].ng) pulse_ng();
            kd = 5'(vecs[i].key);
            key_valid = 1'b1;
            step();
            key_valid = 1'b0;
            chk($sformatf("v%0d_reject", i), int'(rej), int'(vecs[i].rej));
            n = 0;
            while (bsy && n < 40) begin
                step();
                n++;
            end
            chk($sformatf("v%0d_latency", i), n, vecs[i].rej ? 0 : 22);
            chk($sformatf("v%0d_turn", i), int'(trn), int'(vecs[i].turn));
            chk($sformatf("v%0d_count", i), int'(mc), vecs[i].cnt);
            chk($sformatf("v%0d_result", i), int'(res), vecs[i].res);
            chk($sformatf("v%0d_key_ready", i), int'(kr), vecs[i].res == 0 ? 1 : 0);
            step();
            chk($sformatf("v%0d_reject_clear", i), int'(rej), 0);
        end

        // new_game during the tenth CHECK cycle
        sel = 1'b0;
        pulse_ng();
        kd = 5'd5; key_valid = 1'b1;
        step();
        key_valid = 1'b0;
        repeat (10) step();
        chk("ng_mid_busy", int'(bsy), 1);
        chk("ng_mid_board_set", int'(brd3 != 18'd0), 1);
        new_game = 1'b1;
        step();
        new_game = 1'b0;
        chk("ng_board", int'(brd3), 0);
        chk("ng_result", int'(res), 0);
        chk("ng_turn", int'(trn), 0);
        chk("ng_count", int'(mc), 0);
        chk("ng_busy", int'(bsy), 0);
        chk("ng_key_ready", int'(kr), 1);

        // new_game together with a handshake drops the key
        kd = 5'd1; key_valid = 1'b1; new_game = 1'b1;
        step();
        key_valid = 1'b0; new_game = 1'b0;
        chk("ng_key_busy", int'(bsy), 0);
        chk("ng_key_count", int'(mc), 0);
        chk("ng_key_board", int'(brd3), 0);

        // rst mid-CHECK while the menu is up
        kd = 5'd5; key_valid = 1'b1;
        step();
        key_valid = 1'b0;
        repeat (6) step();
        is_main = 1'b1; rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_board", int'(brd3), 0);
        chk("rst_mid_result", int'(res), 0);
        chk("rst_mid_count", int'(mc), 0);
        chk("rst_mid_turn", int'(trn), 0);
        chk("rst_mid_busy", int'(bsy), 0);
        chk("rst_mid_reject", int'(rej), 0);
        chk("rst_mid_key_ready", int'(kr), 0);
        step();
        chk("menu_key_ready", int'(kr), 0);
        is_main = 1'b0;
        #1;
        chk("menu_off_key_ready", int'(kr), 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
